// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the on-chip memory reader: state encoding and bus constants.
package onchip_mem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StHold = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  BE_ALL     = 4'hF;

endpackage

// File: rtl/onchip_mem_reader.sv
// Avalon-MM read master: reads word_count words from base_addr one transfer at a time,
// forwards each word on a valid/ready stream and accumulates a 32-bit checksum.
module onchip_mem_reader
  import onchip_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              out_valid,
  output logic [31:0]       out_data,
  input  logic              out_ready
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [31:0]       sum_q, sum_d;
  logic [31:0]       data_q, data_d;

  // State and datapath registers; async reset kills any in-flight request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      sum_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: one read per word, then hold the word until the consumer takes it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sum_d = '0;
          if (word_count != '0) begin
            addr_d  = {base_addr[ADDR_W-1:2], 2'b00};
            rem_d   = word_count;
            state_d = StRead;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRead: begin
        if (!avm_waitrequest) begin
          data_d  = avm_readdata;
          sum_d   = sum_q + avm_readdata;
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          if (rem_q == CNT_W'(1)) begin
            state_d = StDone;
          end else begin
            rem_d   = rem_q - CNT_W'(1);
            // Address wraps naturally at the top of the byte-address space.
            addr_d  = addr_q + ADDR_W'(WORD_BYTES);
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode straight from the state register so reset clears them asynchronously.
  always_comb begin
    busy           = (state_q != StIdle);
    done           = (state_q == StDone);
    avm_read       = (state_q == StRead);
    out_valid      = (state_q == StHold);
    avm_address    = addr_q;
    avm_byteenable = BE_ALL;
    checksum       = sum_q;
    out_data       = data_q;
  end

endmodule

// File: tb/tb_onchip_mem_reader.sv
// Self-checking bench for onchip_mem_reader: memory model, randomized slave stalls and
// consumer backpressure, scoreboard of expected addresses, words and checksum.
module tb_onchip_mem_reader;

  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned MAX_CYC = 4000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest = 1'b0;
  logic              out_valid;
  logic [31:0]       out_data;
  logic              out_ready = 1'b1;

  logic [31:0] mem [512];

  onchip_mem_reader #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .checksum       (checksum),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_byteenable (avm_byteenable),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  // Slave returns the addressed word; waitrequest decides when it counts.
  assign avm_readdata = mem[avm_address[ADDR_W-1:2]];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard state shared between the job tasks and the monitor.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int unsigned rd_seen, st_seen, done_seen;
  int unsigned wmode = 0, rmode = 0, wcnt = 0, rcnt = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave stall and consumer backpressure generators.
  initial forever begin
    @(posedge clk);
    #1;
    case (wmode)
      1: begin
        if (avm_read && wcnt < 3) begin
          avm_waitrequest = 1'b1;
          wcnt++;
        end else begin
          avm_waitrequest = 1'b0;
          wcnt = 0;
        end
      end
      2: avm_waitrequest = ($urandom_range(0, 3) == 0);
      default: avm_waitrequest = 1'b0;
    endcase
    case (rmode)
      1: out_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (out_valid && st_seen == 1 && rcnt < 5) begin
          out_ready = 1'b0;
          rcnt++;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Protocol monitor: stability under stall/backpressure, exclusivity, ordered data.
  initial begin
    logic              prev_stall, prev_hold;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    prev_stall = 1'b0;
    prev_hold  = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        prev_hold  = 1'b0;
      end else begin
        if (busy) chk("read_valid_excl", 32'(avm_read & out_valid), 32'd0);
        if (prev_stall) begin
          chk("stall_read", 32'(avm_read), 32'd1);
          chk("stall_addr", 32'(avm_address), 32'(prev_addr));
        end
        if (prev_hold) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", out_data, prev_data);
        end
        if (avm_read && !avm_waitrequest) begin
          rd_seen++;
          if (exp_addr_q.size() > 0) chk("rd_addr", 32'(avm_address), exp_addr_q.pop_front());
        end
        if (out_valid && out_ready) begin
          st_seen++;
          if (exp_data_q.size() > 0) chk("st_data", out_data, exp_data_q.pop_front());
        end
        if (done) done_seen++;
        prev_stall = avm_read && avm_waitrequest;
        prev_hold  = out_valid && !out_ready;
        prev_addr  = avm_address;
        prev_data  = out_data;
      end
    end
  end

  // Build expected traffic from the memory image using plain arithmetic.
  task automatic plan_job(input int unsigned base, input int unsigned cnt,
                          output logic [31:0] sum);
    int unsigned a0, ba;
    a0 = (base / 4) * 4;
    sum = '0;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int unsigned i = 0; i < cnt; i++) begin
      ba = (a0 + 4 * i) % (1 << ADDR_W);
      exp_addr_q.push_back(32'(ba));
      exp_data_q.push_back(mem[ba / 4]);
      sum = sum + mem[ba / 4];
    end
    rd_seen   = 0;
    st_seen   = 0;
    done_seen = 0;
    wcnt      = 0;
    rcnt      = 0;
  endtask

  task automatic pulse_start(input int unsigned base, input int unsigned cnt);
    @(posedge clk);
    #1;
    start      = 1'b1;
    base_addr  = ADDR_W'(base);
    word_count = CNT_W'(cnt);
  endtask

  task automatic run_job(input string name, input int unsigned base, input int unsigned cnt,
                         input int unsigned wm, input int unsigned rm, input bit timed,
                         input bit restart);
    logic [31:0] sum;
    int unsigned t0, n;
    wmode = wm;
    rmode = rm;
    plan_job(base, cnt, sum);
    pulse_start(base, cnt);
    t0 = cyc;
    @(posedge clk);
    #1;
    start      = 1'b0;
    base_addr  = ADDR_W'($urandom);
    word_count = CNT_W'($urandom);
    if (restart) begin
      // A second start mid-job must be ignored.
      pulse_start(base + 256, cnt + 7);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < MAX_CYC);
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    if (timed) chk({name, "_done_lat"}, cyc - t0, 2 * cnt + 1);
    @(negedge clk);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_done_once"}, done_seen, 32'd1);
    chk({name, "_checksum"}, checksum, sum);
    chk({name, "_reads"}, rd_seen, cnt);
    chk({name, "_words"}, st_seen, cnt);
  endtask

  task automatic reset_mid_job();
    logic [31:0] sum;
    int unsigned n;
    wmode = 0;
    rmode = 2;
    plan_job(32'h40, 4, sum);
    pulse_start(32'h40, 4);
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && st_seen == 1) && n < 200);
    chk("rst_hold2_reached", 32'(out_valid), 32'd1);
    chk("rst_busy_mid", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    done_seen = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rmode = 0;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done_seen, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'(i + 1);
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_checksum", checksum, 32'd0);
    chk("reset_byteenable", 32'(avm_byteenable), 32'hF);
    chk("reset_avm_read", 32'(avm_read), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_avm_address", 32'(avm_address), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_job("t1", 0, 4, 0, 0, 1'b1, 1'b0);
    chk("t1_sum_const", checksum, 32'd10);
    run_job("t2", 0, 4, 1, 0, 1'b0, 1'b0);
    chk("t2_sum_const", checksum, 32'd10);
    run_job("t3", 0, 4, 0, 2, 1'b0, 1'b0);
    run_job("t4", 0, 0, 0, 0, 1'b1, 1'b0);
    chk("t4_sum_const", checksum, 32'd0);

    mem[510] = 32'hFFFF_FFFF;
    mem[511] = 32'hFFFF_FFFF;
    mem[0]   = 32'hFFFF_FFFF;
    run_job("t5", 32'h7F8, 3, 0, 0, 1'b1, 1'b0);
    chk("t5_sum_const", checksum, 32'hFFFF_FFFD);

    reset_mid_job();
    run_job("t6_after_rst", 32'h13, 5, 0, 0, 1'b1, 1'b0);
    run_job("t6_restart", 32'h20, 6, 2, 1, 1'b0, 1'b1);

    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    for (int j = 0; j < 10; j++) begin
      int unsigned wm, rm;
      wm = $urandom_range(0, 2);
      rm = $urandom_range(0, 1);
      run_job("rand", $urandom_range(0, 2047), $urandom_range(0, 20), wm, rm,
              (wm == 0 && rm == 0), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
